// File: rtl/integration_depacketizer.sv
// Stream depacketizer: validates header/length/framing of 64-bit packets and commits
// per-channel statistics into a double-buffered bank with a registered read port.
`timescale 1ns/1ps
module integration_depacketizer #(
  parameter int          NUM_CH = 16,
  parameter logic [7:0]  ID     = 8'hAA
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [63:0]               s_tdata,
  input  logic                      s_tvalid,
  input  logic                      s_tlast,
  output logic                      s_tready,
  output logic                      rec_valid,
  output logic [63:0]               rec_ts,
  output logic [3:0]                rec_region,
  output logic [59:0]               rec_pkt_counter,
  output logic [63:0]               rec_samples,
  input  logic [$clog2(NUM_CH)-1:0] rd_ch,
  output logic [63:0]               rd_count,
  output logic signed [63:0]        rd_sum,
  output logic signed [63:0]        rd_sumsq,
  output logic                      err_id,
  output logic                      err_len,
  output logic                      err_frame,
  output logic [31:0]               cnt_ok,
  output logic [31:0]               cnt_err,
  output logic [31:0]               cnt_gap
);

  localparam int PLEN = 3 + 3 * NUM_CH;
  localparam int IW   = $clog2(PLEN + 1);
  localparam int CW   = $clog2(NUM_CH);
  localparam logic [IW-1:0] LAST_IDX = IW'(PLEN - 1);
  localparam logic [IW-1:0] CNT_BASE = IW'(3);
  localparam logic [IW-1:0] SUM_BASE = IW'(3 + NUM_CH);
  localparam logic [IW-1:0] SQ_BASE  = IW'(3 + 2 * NUM_CH);
  localparam logic [15:0]   PLEN_W   = 16'(PLEN);

  typedef enum logic [1:0] {HDR, PAY, DISCARD} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            acc, wr_en, commit, e_id, e_len, e_frame;
  logic            act_q, shadow;
  logic [1:0]      bank_ok_q;
  logic [CW-1:0]   wr_ch;
  logic            have_prev_q;
  logic [59:0]     prev_pkt_q;
  logic [63:0]     ts_sh, meta_sh, samp_sh;
  logic [63:0]        cnt_mem [2][NUM_CH];
  logic signed [63:0] sum_mem [2][NUM_CH];
  logic signed [63:0] sq_mem  [2][NUM_CH];

  assign s_tready = ~rst;
  assign acc      = s_tvalid & s_tready;
  assign shadow   = ~act_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    commit  = 1'b0;
    e_id    = 1'b0;
    e_len   = 1'b0;
    e_frame = 1'b0;
    if (acc) begin
      case (state_q)
        HDR: begin
          if (s_tdata[63:56] != ID) begin
            e_id = 1'b1;
            if (!s_tlast) state_d = DISCARD;
          end else if (s_tdata[15:0] != PLEN_W) begin
            e_len = 1'b1;
            if (!s_tlast) state_d = DISCARD;
          end else if (s_tlast) begin
            e_frame = 1'b1;
          end else begin
            idx_d   = '0;
            state_d = PAY;
          end
        end
        PAY: begin
          wr_en = 1'b1;
          idx_d = idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
            if (s_tlast) begin
              commit  = 1'b1;
              state_d = HDR;
            end else begin
              e_frame = 1'b1;
              state_d = DISCARD;
            end
          end else if (s_tlast) begin
            // Short packet: shadow contents are simply never committed
            e_frame = 1'b1;
            state_d = HDR;
          end
        end
        DISCARD: if (s_tlast) state_d = HDR;
        default: state_d = HDR;
      endcase
    end
  end

  always_comb begin
    if (idx_q < SUM_BASE)     wr_ch = CW'(idx_q - CNT_BASE);
    else if (idx_q < SQ_BASE) wr_ch = CW'(idx_q - SUM_BASE);
    else                      wr_ch = CW'(idx_q - SQ_BASE);
  end

  // Shadow-bank capture: header fields in idx 0..2, channel arrays after
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (idx_q == IW'(0))      ts_sh   <= s_tdata;
      else if (idx_q == IW'(1)) meta_sh <= s_tdata;
      else if (idx_q == IW'(2)) samp_sh <= s_tdata;
      else if (idx_q < SUM_BASE) cnt_mem[shadow][wr_ch] <= s_tdata;
      else if (idx_q < SQ_BASE)  sum_mem[shadow][wr_ch] <= s_tdata;
      else                       sq_mem[shadow][wr_ch]  <= s_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= HDR;
      idx_q           <= '0;
      act_q           <= 1'b0;
      bank_ok_q       <= 2'b00;
      rec_valid       <= 1'b0;
      err_id          <= 1'b0;
      err_len         <= 1'b0;
      err_frame       <= 1'b0;
      rec_ts          <= '0;
      rec_region      <= '0;
      rec_pkt_counter <= '0;
      rec_samples     <= '0;
      cnt_ok          <= '0;
      cnt_err         <= '0;
      cnt_gap         <= '0;
      have_prev_q     <= 1'b0;
      prev_pkt_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rec_valid <= commit;
      err_id    <= e_id;
      err_len   <= e_len;
      err_frame <= e_frame;
      if (e_id | e_len | e_frame) cnt_err <= cnt_err + 32'd1;
      if (commit) begin
        act_q             <= shadow;
        bank_ok_q[shadow] <= 1'b1;
        rec_ts            <= ts_sh;
        rec_region        <= meta_sh[63:60];
        rec_pkt_counter   <= meta_sh[59:0];
        rec_samples       <= samp_sh;
        cnt_ok            <= cnt_ok + 32'd1;
        // 60-bit add wraps, so 2^60-1 -> 0 is treated as in sequence
        if (have_prev_q && (meta_sh[59:0] != prev_pkt_q + 60'd1)) cnt_gap <= cnt_gap + 32'd1;
        prev_pkt_q  <= meta_sh[59:0];
        have_prev_q <= 1'b1;
      end
    end
  end

  // Registered read of the active bank; a never-committed bank reads as zero
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      rd_sum   <= '0;
      rd_sumsq <= '0;
    end else if (bank_ok_q[act_q]) begin
      rd_count <= cnt_mem[act_q][rd_ch];
      rd_sum   <= sum_mem[act_q][rd_ch];
      rd_sumsq <= sq_mem[act_q][rd_ch];
    end else begin
      rd_count <= '0;
      rd_sum   <= '0;
      rd_sumsq <= '0;
    end
  end

endmodule

// File: tb/tb_integration_depacketizer.sv
// Randomized bench for integration_depacketizer with a packet-level reference model.
`timescale 1ns/1ps
module tb_integration_depacketizer;
  localparam int N    = 16;
  localparam int PLEN = 51;
  localparam int EV_NONE = 0, EV_ID = 1, EV_LEN = 2, EV_FRAME = 3, EV_COMMIT = 4;

  logic        clk, rst;
  logic [63:0] s_tdata;
  logic        s_tvalid, s_tlast, s_tready;
  logic        rec_valid;
  logic [63:0] rec_ts, rec_samples;
  logic [3:0]  rec_region;
  logic [59:0] rec_pkt_counter;
  logic [3:0]  rd_ch;
  logic [63:0] rd_count;
  logic signed [63:0] rd_sum, rd_sumsq;
  logic        err_id, err_len, err_frame;
  logic [31:0] cnt_ok, cnt_err, cnt_gap;

  integration_depacketizer dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .rec_valid(rec_valid), .rec_ts(rec_ts), .rec_region(rec_region),
    .rec_pkt_counter(rec_pkt_counter), .rec_samples(rec_samples), .rd_ch(rd_ch),
    .rd_count(rd_count), .rd_sum(rd_sum), .rd_sumsq(rd_sumsq), .err_id(err_id),
    .err_len(err_len), .err_frame(err_frame), .cnt_ok(cnt_ok), .cnt_err(cnt_err),
    .cnt_gap(cnt_gap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;
  int rd_fix = -1;

  logic [63:0] pkt_w [0:127];
  int          pkt_n;

  // Reference model state (what the outputs must be after the current edge)
  logic        m_rec_valid, m_err_id, m_err_len, m_err_frame;
  logic [63:0] m_ts, m_samples;
  logic [3:0]  m_region;
  logic [59:0] m_pkt, m_prev;
  logic        m_have_prev;
  logic [31:0] m_ok, m_err, m_gap;
  logic [63:0] m_cnt [N];
  logic [63:0] m_sum [N];
  logic [63:0] m_sq  [N];
  logic [63:0] m_rd_count, m_rd_sum, m_rd_sq;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input int ev);
    if (rst) begin
      {m_rec_valid, m_err_id, m_err_len, m_err_frame} = '0;
      m_ts = '0; m_samples = '0; m_region = '0; m_pkt = '0; m_prev = '0; m_have_prev = 1'b0;
      m_ok = '0; m_err = '0; m_gap = '0;
      m_rd_count = '0; m_rd_sum = '0; m_rd_sq = '0;
      for (int c = 0; c < N; c++) begin m_cnt[c] = '0; m_sum[c] = '0; m_sq[c] = '0; end
    end else begin
      {m_rec_valid, m_err_id, m_err_len, m_err_frame} = '0;
      m_rd_count = m_cnt[rd_ch];
      m_rd_sum   = m_sum[rd_ch];
      m_rd_sq    = m_sq[rd_ch];
      case (ev)
        EV_ID:    begin m_err_id = 1'b1;    m_err = m_err + 1; end
        EV_LEN:   begin m_err_len = 1'b1;   m_err = m_err + 1; end
        EV_FRAME: begin m_err_frame = 1'b1; m_err = m_err + 1; end
        EV_COMMIT: begin
          m_rec_valid = 1'b1;
          m_ok = m_ok + 1;
          m_ts = pkt_w[1];
          m_region = pkt_w[2][63:60];
          m_pkt = pkt_w[2][59:0];
          m_samples = pkt_w[3];
          if (m_have_prev && (m_pkt != m_prev + 60'd1)) m_gap = m_gap + 1;
          m_prev = m_pkt;
          m_have_prev = 1'b1;
          for (int c = 0; c < N; c++) begin
            m_cnt[c] = pkt_w[4 + c];
            m_sum[c] = pkt_w[4 + N + c];
            m_sq[c]  = pkt_w[4 + 2 * N + c];
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input int ev);
    @(posedge clk);
    #1;
    model_update(ev);
    rd_ch = (rd_fix >= 0) ? rd_fix[3:0] : 4'($urandom_range(15));
  endtask

  // Whole-packet verdict: which word (0 = header) raises which event
  task automatic classify(output int ev, output int at);
    if (pkt_w[0][63:56] != 8'hAA)          begin ev = EV_ID;     at = 0; end
    else if (pkt_w[0][15:0] != 16'(PLEN))  begin ev = EV_LEN;    at = 0; end
    else if (pkt_n == 1)                   begin ev = EV_FRAME;  at = 0; end
    else if (pkt_n - 1 < PLEN)             begin ev = EV_FRAME;  at = pkt_n - 1; end
    else if (pkt_n - 1 > PLEN)             begin ev = EV_FRAME;  at = PLEN; end
    else                                   begin ev = EV_COMMIT; at = pkt_n - 1; end
  endtask

  task automatic make_good(input logic [59:0] pc, input logic [3:0] rg);
    pkt_n = 1 + PLEN;
    pkt_w[0] = 64'hAA00_0000_0000_0033;
    pkt_w[2] = {rg, pc};
    for (int k = 1; k < pkt_n + 12; k++)
      if (k != 2) pkt_w[k] = {$urandom, $urandom};
  endtask

  task automatic send_pkt(input bit partial);
    int ev, at;
    if (partial) begin ev = EV_NONE; at = -1; end
    else classify(ev, at);
    for (int k = 0; k < pkt_n; k++) begin
      repeat ($urandom_range(2)) begin
        s_tvalid = 1'b0;
        s_tdata  = {$urandom, $urandom};
        s_tlast  = 1'($urandom_range(1));
        step(EV_NONE);
      end
      s_tvalid = 1'b1;
      s_tdata  = pkt_w[k];
      s_tlast  = !partial && (k == pkt_n - 1);
      step((k == at) ? ev : EV_NONE);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    repeat (cycles) step(EV_NONE);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("s_tready", 64'(s_tready), 64'(!rst));
      cmp("rec_valid", 64'(rec_valid), 64'(m_rec_valid));
      cmp("err_id", 64'(err_id), 64'(m_err_id));
      cmp("err_len", 64'(err_len), 64'(m_err_len));
      cmp("err_frame", 64'(err_frame), 64'(m_err_frame));
      cmp("rec_ts", rec_ts, m_ts);
      cmp("rec_region", 64'(rec_region), 64'(m_region));
      cmp("rec_pkt_counter", 64'(rec_pkt_counter), 64'(m_pkt));
      cmp("rec_samples", rec_samples, m_samples);
      cmp("rd_count", rd_count, m_rd_count);
      cmp("rd_sum", rd_sum, m_rd_sum);
      cmp("rd_sumsq", rd_sumsq, m_rd_sq);
      cmp("cnt_ok", 64'(cnt_ok), 64'(m_ok));
      cmp("cnt_err", 64'(cnt_err), 64'(m_err));
      cmp("cnt_gap", 64'(cnt_gap), 64'(m_gap));
    end
  end

  initial begin
    logic [63:0] prev_c2;
    logic [59:0] next_pc;
    int t;
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; rd_ch = '0;

    step(EV_NONE);
    chk_on = 1'b1;
    do_reset(2);
    @(negedge clk);
    cmp("reset_cnt_ok", 64'(cnt_ok), 64'd0);
    cmp("reset_rd_count", rd_count, 64'd0);

    // Good packet with hand-known fields
    make_good(60'd5, 4'd3);
    pkt_w[1] = 64'h1234;
    pkt_w[6] = 64'd7;
    pkt_w[4 + N + 2] = 64'hFFFF_FFFF_FFFF_FFF7;
    send_pkt(1'b0);
    @(negedge clk);
    cmp("good_rec_valid", 64'(rec_valid), 64'd1);
    cmp("good_pkt", 64'(rec_pkt_counter), 64'd5);
    cmp("good_region", 64'(rec_region), 64'd3);
    cmp("good_ts", rec_ts, 64'h1234);
    cmp("good_cnt_ok", 64'(cnt_ok), 64'd1);
    cmp("model_pkt", 64'(m_pkt), 64'd5);
    rd_fix = 2; rd_ch = 4'd2;
    step(EV_NONE);
    @(negedge clk);
    cmp("good_rd_count", rd_count, 64'd7);
    cmp("good_rd_sum", rd_sum, 64'hFFFF_FFFF_FFFF_FFF7);
    rd_fix = -1;

    // Bad ID, then recovery
    make_good(60'd6, 4'd1);
    pkt_w[0][63:56] = 8'hAB;
    send_pkt(1'b0);
    @(negedge clk);
    cmp("badid_cnt_err", 64'(cnt_err), 64'd1);
    cmp("badid_cnt_ok", 64'(cnt_ok), 64'd1);
    make_good(60'd6, 4'd1);
    send_pkt(1'b0);
    @(negedge clk);
    cmp("recover_cnt_ok", 64'(cnt_ok), 64'd2);
    prev_c2 = pkt_w[6];

    // Early tlast on payload word 10
    make_good(60'd7, 4'd0);
    pkt_n = 1 + 11;
    send_pkt(1'b0);
    rd_fix = 2; rd_ch = 4'd2;
    step(EV_NONE);
    @(negedge clk);
    cmp("early_rd_count", rd_count, prev_c2);
    cmp("early_cnt_ok", 64'(cnt_ok), 64'd2);
    cmp("early_cnt_err", 64'(cnt_err), 64'd2);
    rd_fix = -1;

    // Sequence gaps including the 60-bit wrap
    do_reset(2);
    make_good(60'd5, 4'd0); send_pkt(1'b0);
    make_good(60'd7, 4'd0); send_pkt(1'b0);
    make_good({60{1'b1}}, 4'd0); send_pkt(1'b0);
    make_good(60'd0, 4'd0); send_pkt(1'b0);
    @(negedge clk);
    cmp("gap_cnt_gap", 64'(cnt_gap), 64'd2);
    cmp("gap_cnt_ok", 64'(cnt_ok), 64'd4);
    cmp("model_gap", 64'(m_gap), 64'd2);

    // Missing tlast: 60 payload words
    make_good(60'd1, 4'd0);
    pkt_n = 1 + 60;
    send_pkt(1'b0);
    @(negedge clk);
    cmp("long_cnt_err", 64'(cnt_err), 64'd1);
    make_good(60'd1, 4'd2);
    send_pkt(1'b0);
    @(negedge clk);
    cmp("long_recover_ok", 64'(cnt_ok), 64'd5);
    cmp("long_recover_pkt", 64'(rec_pkt_counter), 64'd1);

    // Reset in the middle of a packet
    make_good(60'd9, 4'd0);
    pkt_n = 1 + 20;
    send_pkt(1'b1);
    do_reset(2);
    @(negedge clk);
    cmp("midrst_cnt_ok", 64'(cnt_ok), 64'd0);
    cmp("midrst_cnt_err", 64'(cnt_err), 64'd0);
    make_good(60'd9, 4'd0);
    send_pkt(1'b0);
    @(negedge clk);
    cmp("midrst_after_ok", 64'(cnt_ok), 64'd1);

    // Randomized packet mix
    next_pc = 60'd10;
    for (int i = 0; i < 40; i++) begin
      t = $urandom_range(5);
      make_good(($urandom_range(3) == 0) ? {$urandom, $urandom} : next_pc, 4'($urandom_range(15)));
      next_pc = pkt_w[2][59:0] + 60'd1;
      case (t)
        2: begin pkt_w[0][63:56] = 8'($urandom_range(169)); pkt_n = $urandom_range(1, 55); end
        3: begin pkt_w[0][15:0] = 16'($urandom_range(50)); pkt_n = $urandom_range(1, 55); end
        4: pkt_n = $urandom_range(1, 60);
        5: pkt_w[0][55:16] = {$urandom, 8'($urandom)};
        default: ;
      endcase
      send_pkt(1'b0);
    end
    repeat (3) step(EV_NONE);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/integration_depacketizer.md
INTEGRATION_DEPACKETIZER -- requirements
Module: integration_depacketizer

Interface
REQ-001 SHALL have parameter NUM_CH, default 16, the number of ADC channels per record.
REQ-002 SHALL have parameter ID, default 8'hAA, the expected packet ID byte.
REQ-003 SHALL have localparam PLEN = 3+3*NUM_CH (51 by default), the expected payload word count.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic SHALL run on its rising edge.
REQ-005 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-006 SHALL have port s_tdata, input, 64, the stream data word.
REQ-007 SHALL have ports s_tvalid (input, 1) and s_tlast (input, 1), the stream valid and end-of-packet flags.
REQ-008 SHALL have port s_tready, output, 1, the stream ready.
REQ-009 SHALL have port rec_valid, output, 1, a one-cycle pulse marking a newly committed record.
REQ-010 SHALL have ports rec_ts (output, 64), rec_region (output, 4), rec_pkt_counter (output, 60) and rec_samples (output, 64), the committed header fields.
REQ-011 SHALL have port rd_ch, input, $clog2(NUM_CH), the channel read address.
REQ-012 SHALL have ports rd_count, rd_sum and rd_sumsq, output, 64 each, the committed channel data.
REQ-013 SHALL have ports err_id, err_len and err_frame, output, 1 each, one-cycle error pulses.
REQ-014 SHALL have ports cnt_ok, cnt_err and cnt_gap, output, 32 each, free-running statistics counters.

Function
REQ-015 The packet format SHALL be:
- header word: [63:56] = ID, [15:0] = payload length; all other bits ignored.
- payload word 0: cap_ts.
- payload word 1: {region[3:0], pkt_counter[59:0]}.
- payload word 2: samples_captured.
- words 3..3+NUM_CH-1: ch_count[0..NUM_CH-1].
- next NUM_CH words: ch_sum[0..].
- last NUM_CH words: ch_sumsq[0..].
REQ-016 A word SHALL be accepted only in a cycle where s_tvalid and s_tready are both high.
REQ-017 s_tready SHALL be 0 while rst is high and 1 in every cycle after reset; the block SHALL never stall.
REQ-018 The FSM SHALL have states HDR, PAY and DISCARD, and SHALL be in HDR after reset.
REQ-019 In HDR, an accepted word SHALL be handled as follows:
- ID mismatch: pulse err_id and go to DISCARD, or stay in HDR if tlast=1.
- length != PLEN: pulse err_len and go to DISCARD, or stay in HDR if tlast=1.
- tlast=1 on an otherwise valid header: pulse err_frame and stay in HDR.
- otherwise: clear the word index and go to PAY.
REQ-020 In PAY, each accepted word SHALL be written into the shadow bank at the current index, and the index SHALL then increment.
REQ-021 In PAY, tlast=1 with index < PLEN-1 SHALL pulse err_frame, return to HDR and discard the shadow bank.
REQ-022 In PAY, index = PLEN-1 with tlast=0 SHALL pulse err_frame and go to DISCARD.
REQ-023 In PAY, index = PLEN-1 with tlast=1 SHALL commit the record.
REQ-024 In DISCARD, words SHALL be accepted and dropped, and the FSM SHALL return to HDR on the word carrying tlast.
REQ-025 Storage SHALL be double-buffered: a committing word SHALL swap the active and shadow banks, and rec_* SHALL update with rec_valid=1 in the cycle after the last word.
REQ-026 rd_count, rd_sum and rd_sumsq SHALL be registered reads of the active bank, giving one-cycle latency from rd_ch.
REQ-027 A read issued in the same cycle as a commit SHALL return data from the old bank.
REQ-028 Each error pulse SHALL increment cnt_err by 1, and each commit SHALL increment cnt_ok by 1.
REQ-029 Sequence gap checking SHALL apply from the second commit after reset onward: a pkt_counter not equal to prev+1 (mod 2^60) SHALL increment cnt_gap, and the record SHALL still be committed.
REQ-030 A wrap of pkt_counter from 2^60-1 to 0 SHALL NOT count as a gap.
REQ-031 All counters SHALL wrap at 2^32 without saturating.
REQ-032 rd_sum and rd_sumsq SHALL be passed through as signed 64-bit values with no arithmetic applied.

Reset
REQ-033 Reset SHALL force the following:
- FSM = HDR and word index = 0.
- s_tready = 0; rec_valid, err_id, err_len and err_frame = 0.
- rec_ts, rec_region, rec_pkt_counter, rec_samples = 0.
- rd_count, rd_sum, rd_sumsq = 0; both banks read as 0.
- cnt_ok, cnt_err, cnt_gap = 0; the gap reference is cleared.
REQ-034 Reset asserted in the middle of a packet SHALL abandon that packet without a commit or error pulse.
REQ-035 After reset, words received before the next header SHALL be treated as a header.

Verification
REQ-036 Good packet: header 0xAA00_0000_0000_0033, ts=0x1234, pkt=5, region=3, ch_count[2]=7, ch_sum[2]=-9 -> rec_valid 1 cycle after tlast, rec_pkt_counter=5, rec_region=3, rd_ch=2 gives rd_count=7 and rd_sum=0xFFFF_FFFF_FFFF_FFF7, cnt_ok=1.
REQ-037 Bad ID: header ID 0xAB followed by 51 words with tlast on the last -> err_id pulses once, no rec_valid, cnt_err=1, FSM back in HDR and the next good packet commits.
REQ-038 Early tlast on payload word 10 -> err_frame pulses, no commit, previous record still readable unchanged.
REQ-039 Gaps: packets with pkt=5, 7, then 2^60-1, then 0 -> cnt_gap=2, cnt_ok=4.
REQ-040 Missing tlast: 60 payload words with tlast only on word 60 -> err_frame at word 51, DISCARD, then recovery on the next header.
REQ-041 Reset mid-packet at payload word 20, then a good packet -> no error pulse, counters=0 before the good packet, cnt_ok=1 after it.
